// File: rtl/ex1_sweep_capture.sv
// Self-test sequencer: sweeps {a,b,c,d} through 0..15, captures f3 per vector
// into a truth table and compares it against the EXPECTED mask.
module ex1_sweep_capture #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'hB1B1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f3,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_tbl,
  output logic        pass,
  output logic [4:0]  mismatch_cnt
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      k;
  logic [3:0]      vec;
  logic [SW-1:0]   scnt;
  logic            start_ok;
  logic            sample;

  always_comb begin
    start_ok = start && (state != BUSY);
    sample   = (state == BUSY) && !hold && (scnt == SLAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (sample && (k == 4'd15)) state_nxt = DONE;
      DONE:    if (start) state_nxt = BUSY;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector index, settle counter and capture; frozen entirely while hold is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      k            <= '0;
      vec          <= '0;
      scnt         <= '0;
      truth_tbl    <= '0;
      mismatch_cnt <= '0;
    end else if (start_ok) begin
      k            <= '0;
      vec          <= '0;
      scnt         <= '0;
      truth_tbl    <= '0;
      mismatch_cnt <= '0;
    end else if ((state == BUSY) && !hold) begin
      if (scnt != SLAST) begin
        scnt <= scnt + SW'(1);
      end else begin
        truth_tbl[k] <= f3;
        mismatch_cnt <= mismatch_cnt + {4'b0000, (f3 != EXPECTED[k])};
        if (k == 4'd15) begin
          vec <= '0;
        end else begin
          k    <= k + 4'd1;
          vec  <= k + 4'd1;
          scnt <= '0;
        end
      end
    end
  end

  always_comb begin
    busy         = (state == BUSY);
    done         = (state == DONE);
    pass         = done && (truth_tbl == EXPECTED);
    {a, b, c, d} = vec;
  end

endmodule

// File: tb/tb_ex1_sweep_capture.sv
// Bench for ex1_sweep_capture: directed and randomized sweeps checked against
// a vector/latency model derived from the sweep rules.
module tb_ex1_sweep_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start1 = 1'b0;
  logic        hold1  = 1'b0;
  logic        a1, b1, c1, d1;
  logic        f3_1;
  logic        busy1, done1, pass1;
  logic [15:0] truth1;
  logic [4:0]  mm1;
  logic [3:0]  vec1;

  logic        start3 = 1'b0;
  logic        hold3  = 1'b0;
  logic        a3, b3, c3, d3;
  logic        f3_3;
  logic        busy3, done3, pass3;
  logic [15:0] truth3;
  logic [4:0]  mm3;
  logic [3:0]  vec3;

  logic [15:0] golden = 16'hB1B1;
  logic [15:0] tbl_r  = 16'hB1B1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign vec1 = {a1, b1, c1, d1};
  assign vec3 = {a3, b3, c3, d3};
  assign f3_1 = tbl_r[vec1];
  assign f3_3 = golden[vec3];

  ex1_sweep_capture #(.SETTLE(1), .EXPECTED(16'hB1B1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hold(hold1),
    .a(a1), .b(b1), .c(c1), .d(d1), .f3(f3_1),
    .busy(busy1), .done(done1), .truth_tbl(truth1), .pass(pass1),
    .mismatch_cnt(mm1)
  );

  ex1_sweep_capture #(.SETTLE(3), .EXPECTED(16'hB1B1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .hold(hold3),
    .a(a3), .b(b3), .c(c3), .d(d3), .f3(f3_3),
    .busy(busy3), .done(done3), .truth_tbl(truth3), .pass(pass3),
    .mismatch_cnt(mm3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_idle1(input string tag);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_done"}, done1, 0);
    check({tag, "_vec"}, vec1, 0);
    check({tag, "_tbl"}, truth1, 0);
    check({tag, "_mm"}, mm1, 0);
    check({tag, "_pass"}, pass1, 0);
  endtask

  // hold_mode: 0 none, 1 random holds, 2 five held cycles while vector 7 is presented
  task automatic sweep1(input logic [15:0] tbl, input int hold_mode);
    int nonheld;
    int held;
    int cyc;
    tbl_r  = tbl;
    start1 = 1'b1;
    hold1  = ($urandom_range(0, 1) == 1);
    tick();
    start1 = 1'b0;
    check("start_busy", busy1, 1);
    check("start_done", done1, 0);
    check("start_tbl", truth1, 0);
    check("start_mm", mm1, 0);
    check("start_vec", vec1, 0);
    check("start_pass", pass1, 0);
    nonheld = 0;
    held    = 0;
    cyc     = 0;
    while (busy1 && cyc < 200) begin
      check("vec_seq", vec1, nonheld);
      case (hold_mode)
        1:       hold1 = ($urandom_range(0, 3) == 0);
        2:       hold1 = (nonheld == 7) && (held < 5);
        default: hold1 = 1'b0;
      endcase
      start1 = ($urandom_range(0, 7) == 0);
      if (hold1) held++;
      else       nonheld++;
      cyc++;
      tick();
    end
    hold1  = 1'b0;
    start1 = 1'b0;
    check("end_busy", busy1, 0);
    check("end_done", done1, 1);
    check("busy_len", cyc, 16 + held);
    check("end_tbl", truth1, tbl);
    check("end_mm", mm1, $countones(tbl ^ golden));
    check("end_pass", pass1, (tbl == golden));
    check("end_vec", vec1, 0);
    tick();
    check("hold_tbl", truth1, tbl);
    check("hold_done", done1, 1);
    check("hold_mm", mm1, $countones(tbl ^ golden));
  endtask

  initial begin
    int cyc;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle1("rst");
    check("rst3_busy", busy3, 0);
    check("rst3_done", done3, 0);
    check("rst3_tbl", truth3, 0);

    sweep1(16'hB1B1, 0);
    sweep1(16'h0000, 0);
    sweep1(16'hFFFF, 0);
    sweep1(16'hB1B1, 2);

    // reset while vector 9 is presented
    tbl_r  = golden;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 0;
    while (vec1 != 4'd9 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("reach_k9", vec1, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle1("midrst");

    // reset and start together: reset wins
    rst    = 1'b1;
    start1 = 1'b1;
    tick();
    rst    = 1'b0;
    start1 = 1'b0;
    check_idle1("rst_start");

    sweep1(16'hB1B1, 0);
    for (int i = 0; i < 4; i++) begin
      sweep1(16'($urandom), 1);
    end

    // SETTLE=3 instance: each vector held 3 cycles, done after 48 cycles
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 200) begin
      if (cyc < 48) check("vec3_seq", vec3, cyc / 3);
      tick();
      cyc++;
    end
    check("done3_lat", cyc, 48);
    check("done3_tbl", truth3, 16'hB1B1);
    check("done3_mm", mm3, 0);
    check("done3_pass", pass3, 1);
    check("done3_busy", busy3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
